// File: rtl/pipeline_fetch_stage_if.sv
// Handshake bundle between the fetch stage, its instruction ROM and the rest of the pipeline.
// The slave side is the fetch stage itself; the master side is the environment around it.
interface pipeline_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              switchStart;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_en;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] if_id_instr;
    logic [ADDR_W-1:0] if_id_pc;
    logic              if_id_valid;
    logic              running;
    logic              done;

    modport master (
        output switchStart, stall, branch_taken, branch_target, imem_rdata,
        input  imem_addr, imem_en, if_id_instr, if_id_pc, if_id_valid, running, done
    );

    modport slave (
        input  switchStart, stall, branch_taken, branch_target, imem_rdata,
        output imem_addr, imem_en, if_id_instr, if_id_pc, if_id_valid, running, done
    );
endinterface

// File: rtl/pipeline_fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and registers IF/ID.
// Fetching starts on a synchronised rising edge of switchStart and stops at END_ADDR.
module pipeline_fetch_stage #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] END_ADDR = ADDR_W'(32'h0000_0400)
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_fetch_stage_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [ADDR_W-1:0] PcStep    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(PC_STEP - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ipc_q, ipc_d;
    logic              valid_q, valid_d;
    logic              s1_q, s2_q, s3_q;
    logic              sampled_q;
    logic              block_q, block_d;
    logic              start_edge;

    // A switch already high during reset must be seen low before it may start a run;
    // sampled_q marks that s1_q holds a real post-reset sample rather than its reset zero.
    assign block_d    = block_q & ~(sampled_q & ~s1_q);
    assign start_edge = s2_q & ~s3_q & ~block_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            instr_q   <= '0;
            ipc_q     <= '0;
            valid_q   <= 1'b0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            sampled_q <= 1'b0;
            block_q   <= bus.switchStart;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
            s1_q      <= bus.switchStart;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            sampled_q <= 1'b1;
            block_q   <= block_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StRun;
            end
            StRun: begin
                // Redirect beats the end check so a branch out of END_ADDR keeps running.
                if (bus.branch_taken) begin
                    pc_d    = bus.branch_target & AlignMask;
                    instr_d = '0;
                end else if (pc_q == END_ADDR) begin
                    state_d = StDone;
                end else if (bus.stall) begin
                    valid_d = valid_q;
                end else begin
                    instr_d = bus.imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PcStep;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.imem_addr   = pc_q;
    assign bus.imem_en     = (state_q == StRun);
    assign bus.running     = (state_q == StRun);
    assign bus.done        = (state_q == StDone);
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_valid = valid_q;
endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Bench for pipeline_fetch_stage: directed table, hand sequences and a randomised run
// checked against a cycle-level behavioural model (32-bit instance with END_ADDR=0x20).
module tb_pipeline_fetch_stage;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    pipeline_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    pipeline_fetch_stage_if #(.ADDR_W(8), .DATA_W(32)) if_b ();

    pipeline_fetch_stage #(
        .ADDR_W(32), .DATA_W(32), .PC_STEP(4), .END_ADDR(32'h20)
    ) u_dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(if_a)
    );

    pipeline_fetch_stage #(
        .ADDR_W(8), .DATA_W(32), .PC_STEP(4), .END_ADDR(8'h80)
    ) u_dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(if_b)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'hC0DE};
    endfunction

    assign if_a.imem_rdata = rom(if_a.imem_addr);
    assign if_b.imem_rdata = rom(32'(if_b.imem_addr));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference for instance A: mode 0 = waiting, 1 = fetching, 2 = finished.
    int          m_mode;
    logic [31:0] m_pc, m_ipc, m_instr;
    bit          m_valid;
    bit          m_hist[3];   // switch samples taken since reset, [0] newest
    bit          m_fresh;     // no sample taken yet since reset
    bit          m_block;     // switch was high at reset and not yet seen low

    always @(posedge clk) begin : model
        bit go;
        if (!rst_a) begin
            m_mode  = 0;
            m_pc    = 0;
            m_ipc   = 0;
            m_instr = 0;
            m_valid = 0;
            m_hist  = '{0, 0, 0};
            m_fresh = 1;
            m_block = if_a.switchStart;
        end else begin
            go = m_hist[1] && !m_hist[2] && !m_block;
            if (m_block && !m_fresh && !m_hist[0]) m_block = 0;
            m_fresh   = 0;
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = if_a.switchStart;
            if (m_mode == 0) begin
                m_valid = 0;
                if (go) m_mode = 1;
            end else if (m_mode == 2) begin
                m_valid = 0;
            end else if (if_a.branch_taken) begin
                m_pc    = {if_a.branch_target[31:2], 2'b00};
                m_instr = 0;
                m_valid = 0;
            end else if (m_pc == 32'h20) begin
                m_mode  = 2;
                m_valid = 0;
            end else if (!if_a.stall) begin
                m_instr = rom(m_pc);
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    end

    task automatic chk_model();
        chk("rnd_pc", if_a.imem_addr, m_pc);
        chk("rnd_running", 32'(if_a.running), 32'(m_mode == 1));
        chk("rnd_done", 32'(if_a.done), 32'(m_mode == 2));
        chk("rnd_valid", 32'(if_a.if_id_valid), 32'(m_valid));
        chk("rnd_id_pc", if_a.if_id_pc, m_ipc);
        chk("rnd_instr", if_a.if_id_instr, m_instr);
    endtask

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic        v;
        logic        run;
        logic        dn;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // stall / branch / end-of-program rows, starting from pc=0x10, if_id_pc=0xC valid
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 32'h10, 32'h0C, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h00, 32'h10, 32'h0C, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h00, 32'h10, 32'h0C, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h00, 32'h14, 32'h10, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'h42, 32'h40, 32'h10, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h00, 32'h44, 32'h40, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 32'h13, 32'h10, 32'h40, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 32'h14, 32'h10, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 32'h18, 32'h14, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 32'h1C, 32'h18, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h00, 32'h20, 32'h1C, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h00, 32'h20, 32'h1C, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 32'h20, 32'h1C, 1'b0, 1'b0, 1'b1};

        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.switchStart   = 1'b0;
        if_a.stall         = 1'b0;
        if_a.branch_taken  = 1'b0;
        if_a.branch_target = '0;
        if_b.switchStart   = 1'b0;
        if_b.stall         = 1'b0;
        if_b.branch_taken  = 1'b0;
        if_b.branch_target = '0;

        // Reset, then start timing
        repeat (3) tick();
        chk("rst_running", 32'(if_a.running), 0);
        chk("rst_done", 32'(if_a.done), 0);
        chk("rst_valid", 32'(if_a.if_id_valid), 0);
        chk("rst_id_pc", if_a.if_id_pc, 0);
        chk("rst_instr", if_a.if_id_instr, 0);
        chk("rst_pc", if_a.imem_addr, 0);
        rst_a = 1'b1;
        if_a.switchStart = 1'b1;
        tick();
        tick();
        chk("start_e1_running", 32'(if_a.running), 0);
        tick();
        chk("start_e2_running", 32'(if_a.running), 1);
        chk("start_e2_imem_en", 32'(if_a.imem_en), 1);
        chk("start_e2_valid", 32'(if_a.if_id_valid), 0);
        tick();
        chk("first_id_pc", if_a.if_id_pc, 0);
        chk("first_valid", 32'(if_a.if_id_valid), 1);
        chk("first_instr", if_a.if_id_instr, rom(0));
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq_id_pc", if_a.if_id_pc, 32'(4 * k));
        end

        // Stall, branch-under-stall, realignment, end of program
        for (int i = 0; i < 13; i++) begin
            if_a.stall         = tbl[i].st;
            if_a.branch_taken  = tbl[i].br;
            if_a.branch_target = tbl[i].tgt;
            if (i == 12) if_a.switchStart = 1'b0;
            tick();
            chk("tbl_pc", if_a.imem_addr, tbl[i].pc);
            chk("tbl_id_pc", if_a.if_id_pc, tbl[i].ipc);
            chk("tbl_valid", 32'(if_a.if_id_valid), 32'(tbl[i].v));
            chk("tbl_running", 32'(if_a.running), 32'(tbl[i].run));
            chk("tbl_done", 32'(if_a.done), 32'(tbl[i].dn));
            if (tbl[i].br) chk("tbl_instr_flush", if_a.if_id_instr, 0);
            else if (tbl[i].v) chk("tbl_instr", if_a.if_id_instr, rom(tbl[i].ipc));
        end
        if_a.stall        = 1'b0;
        if_a.branch_taken = 1'b0;
        if_a.switchStart  = 1'b1;
        repeat (5) tick();
        chk("done_hold_done", 32'(if_a.done), 1);
        chk("done_hold_running", 32'(if_a.running), 0);

        // Reset mid-run with the switch held high, then restart via low-high
        rst_a = 1'b0;
        if_a.switchStart = 1'b0;
        repeat (2) tick();
        rst_a = 1'b1;
        if_a.switchStart = 1'b1;
        repeat (9) tick();
        chk("midrun_pc", if_a.imem_addr, 32'h18);
        rst_a = 1'b0;
        tick();
        chk("midrst_pc", if_a.imem_addr, 0);
        chk("midrst_running", 32'(if_a.running), 0);
        chk("midrst_valid", 32'(if_a.if_id_valid), 0);
        chk("midrst_id_pc", if_a.if_id_pc, 0);
        chk("midrst_instr", if_a.if_id_instr, 0);
        rst_a = 1'b1;
        repeat (6) tick();
        chk("held_sw_idle", 32'(if_a.running), 0);
        chk("held_sw_pc", if_a.imem_addr, 0);
        if_a.switchStart = 1'b0;
        repeat (3) tick();
        if_a.switchStart = 1'b1;
        repeat (2) tick();
        chk("restart_e1_running", 32'(if_a.running), 0);
        tick();
        chk("restart_running", 32'(if_a.running), 1);
        tick();
        chk("restart_id_pc", if_a.if_id_pc, 0);
        chk("restart_valid", 32'(if_a.if_id_valid), 1);

        // 8-bit PC wrap on instance B
        rst_b = 1'b1;
        if_b.switchStart = 1'b1;
        repeat (3) tick();
        chk("b_running", 32'(if_b.running), 1);
        if_b.branch_taken  = 1'b1;
        if_b.branch_target = 8'hFF;
        tick();
        chk("b_branch_pc", 32'(if_b.imem_addr), 32'hFC);
        chk("b_branch_valid", 32'(if_b.if_id_valid), 0);
        if_b.branch_taken = 1'b0;
        tick();
        chk("b_fetch_fc_id_pc", 32'(if_b.if_id_pc), 32'hFC);
        chk("b_fetch_fc_instr", if_b.if_id_instr, rom(32'hFC));
        chk("b_wrap_pc", 32'(if_b.imem_addr), 0);
        tick();
        chk("b_after_wrap_id_pc", 32'(if_b.if_id_pc), 0);
        chk("b_after_wrap_valid", 32'(if_b.if_id_valid), 1);
        chk("b_after_wrap_pc", 32'(if_b.imem_addr), 4);

        // Randomised traffic on instance A against the model
        for (int c = 0; c < 600; c++) begin
            if_a.stall         = ($urandom % 4) == 0;
            if_a.branch_taken  = ($urandom % 8) == 0;
            if_a.branch_target = 32'($urandom_range(0, 32'h30));
            if (($urandom % 12) == 0) if_a.switchStart = ~if_a.switchStart;
            rst_a = ($urandom % 50) != 0;
            tick();
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
